// File: rtl/vga_capture_if.sv
// Bundle of VGA input timing, capture control and the memory write port
// for the frame grabber.
interface vga_capture_if;
  logic        pix_en;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        VGA_BLANK_N;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;
  logic        start;
  logic        busy;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        frame_done;
  logic        frame_err;

  modport master (
    output pix_en, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B, start,
    input  busy, wr_en, wr_addr, wr_data, frame_done, frame_err
  );

  modport slave (
    input  pix_en, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B, start,
    output busy, wr_en, wr_addr, wr_data, frame_done, frame_err
  );
endinterface

// File: rtl/vga_capture.sv
// Single-frame VGA grabber: on start, waits for vsync, then writes a
// W x H window of active pixels to word-addressed memory.
module vga_capture #(
  parameter int          X0   = 0,
  parameter int          Y0   = 0,
  parameter int          W    = 256,
  parameter int          H    = 256,
  parameter logic [31:0] BASE = 32'd0
) (
  input logic          clk,
  input logic          reset,
  vga_capture_if.slave bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_VS = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [1:0]  state;
  logic [15:0] x_cnt, y_cnt;
  logic        hs_q, vs_q, blank_q;
  logic        last_q;

  logic        hs_fall, vs_fall, blank_fall, in_win, last_px;
  logic [31:0] xc, yc, addr;

  // Edges are taken between successive pixel samples, never raw clk cycles.
  assign hs_fall    = bus.pix_en & hs_q    & ~bus.VGA_HS;
  assign vs_fall    = bus.pix_en & vs_q    & ~bus.VGA_VS;
  assign blank_fall = bus.pix_en & blank_q & ~bus.VGA_BLANK_N;

  assign xc      = {16'h0000, x_cnt};
  assign yc      = {16'h0000, y_cnt};
  assign in_win  = (xc >= 32'(X0)) && (xc < 32'(X0 + W)) &&
                   (yc >= 32'(Y0)) && (yc < 32'(Y0 + H));
  assign last_px = (xc == 32'(X0 + W - 1)) && (yc == 32'(Y0 + H - 1));
  assign addr    = BASE + (yc - 32'(Y0)) * 32'(W) + (xc - 32'(X0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      x_cnt          <= '0;
      y_cnt          <= '0;
      hs_q           <= 1'b0;
      vs_q           <= 1'b0;
      blank_q        <= 1'b0;
      last_q         <= 1'b0;
      bus.busy       <= 1'b0;
      bus.wr_en      <= 1'b0;
      bus.wr_addr    <= '0;
      bus.wr_data    <= '0;
      bus.frame_done <= 1'b0;
      bus.frame_err  <= 1'b0;
    end else begin
      bus.wr_en      <= 1'b0;
      bus.frame_done <= 1'b0;
      last_q         <= 1'b0;
      if (bus.pix_en) begin
        hs_q    <= bus.VGA_HS;
        vs_q    <= bus.VGA_VS;
        blank_q <= bus.VGA_BLANK_N;
      end
      case (state)
        IDLE: if (bus.start) begin
          state         <= WAIT_VS;
          bus.busy      <= 1'b1;
          bus.frame_err <= 1'b0;
        end
        WAIT_VS: if (vs_fall) begin
          state <= CAPTURE;
          x_cnt <= '0;
          y_cnt <= '0;
        end
        CAPTURE: begin
          // last_q marks the cycle the final window write is on the bus
          if (last_q) begin
            state <= DONE;
          end else if (vs_fall) begin
            bus.frame_err <= 1'b1;
            x_cnt         <= '0;
            y_cnt         <= '0;
          end else if (bus.pix_en) begin
            if (hs_fall)
              x_cnt <= '0;
            else if (bus.VGA_BLANK_N && x_cnt != CNT_MAX)
              x_cnt <= x_cnt + 16'd1;
            if (blank_fall && y_cnt != CNT_MAX)
              y_cnt <= y_cnt + 16'd1;
            if (bus.VGA_BLANK_N && in_win) begin
              bus.wr_en   <= 1'b1;
              bus.wr_addr <= addr;
              bus.wr_data <= {8'h00, bus.VGA_R, bus.VGA_G, bus.VGA_B};
              last_q      <= last_px;
            end
          end
        end
        DONE: begin
          bus.frame_done <= 1'b1;
          bus.busy       <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_capture.sv
// Directed bench: a shrunken VGA raster feeds two capture instances (a
// 32x16 window at the origin and a 4x2 window at (100,50), base 16).
module tb_vga_capture;
  localparam int H_ACT = 104, H_FP = 2, H_SYNC = 4, H_TOT = 112;
  localparam int V_ACT = 52,  V_FP = 1, V_SYNC = 2, V_TOT = 56;
  localparam int AW = 32, AH = 16;
  localparam int LIMIT = 30000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic pix_en, hs, vs, blank_n, start;
  logic [7:0] r, g, b;

  vga_capture_if ia ();
  vga_capture_if ib ();

  assign ia.pix_en = pix_en, ia.VGA_HS = hs, ia.VGA_VS = vs, ia.VGA_BLANK_N = blank_n,
         ia.VGA_R = r, ia.VGA_G = g, ia.VGA_B = b, ia.start = start;
  assign ib.pix_en = pix_en, ib.VGA_HS = hs, ib.VGA_VS = vs, ib.VGA_BLANK_N = blank_n,
         ib.VGA_R = r, ib.VGA_G = g, ib.VGA_B = b, ib.start = start;

  vga_capture #(.X0(0), .Y0(0), .W(AW), .H(AH), .BASE(32'd0)) dut_a (
    .clk(clk), .reset(reset), .bus(ia));
  vga_capture #(.X0(100), .Y0(50), .W(4), .H(2), .BASE(32'd16)) dut_b (
    .clk(clk), .reset(reset), .bus(ib));

  // Raster generator; pix_en runs 7 of every 8 clocks.
  int hpos, vpos, phase, cur_h, cur_v;
  int cut_line = -1;
  initial begin
    hpos = 0; vpos = 0; phase = 0; cur_h = 0; cur_v = 0;
    pix_en = 1'b0; hs = 1'b1; vs = 1'b1; blank_n = 1'b0; r = 8'h00; g = 8'h00; b = 8'h00;
    forever begin
      @(negedge clk);
      phase  = (phase + 1) % 8;
      pix_en = (phase != 0);
      if (pix_en) begin
        hs      = !(hpos >= H_ACT + H_FP && hpos < H_ACT + H_FP + H_SYNC);
        vs      = !(vpos >= V_ACT + V_FP && vpos < V_ACT + V_FP + V_SYNC);
        blank_n = (hpos < H_ACT) && (vpos < V_ACT);
        r = blank_n ? 8'(hpos) : 8'h00;
        g = blank_n ? 8'(vpos) : 8'h00;
        b = blank_n ? 8'hAA : 8'h00;
        cur_h = hpos; cur_v = vpos;
        if (hpos == H_TOT - 1) begin
          hpos = 0;
          vpos = (vpos == cut_line) ? V_ACT + V_FP : (vpos + 1) % V_TOT;
        end else begin
          hpos = hpos + 1;
        end
      end
    end
  end

  function automatic logic [31:0] exp_a(input logic [31:0] addr);
    return {8'h00, 8'(addr % AW), 8'(addr / AW), 8'hAA};
  endfunction

  function automatic logic [31:0] exp_b(input logic [31:0] addr);
    logic [31:0] o;
    o = addr - 32'd16;
    return {8'h00, 8'(32'd100 + o % 4), 8'(32'd50 + o / 4), 8'hAA};
  endfunction

  // Write monitors: counts, distinct addresses, and writes that break the model.
  int epoch = 0;
  int wcnt_a, dist_a, bad_a, done_a, wcnt_b, dist_b, bad_b, done_b;
  logic [31:0] d33_a, first_addr_b, first_data_b;
  logic seen_a [0:AW*AH-1];
  logic seen_b [0:7];

  initial begin
    int ep;
    ep = -1;
    forever begin
      @(negedge clk);
      if (ep != epoch) begin
        ep = epoch; wcnt_a = 0; dist_a = 0; bad_a = 0; done_a = 0; d33_a = '0;
        foreach (seen_a[i]) seen_a[i] = 1'b0;
      end
      if (ia.frame_done) done_a++;
      if (ia.wr_en) begin
        wcnt_a++;
        if (ia.wr_addr >= 32'(AW * AH) || !ia.busy || ia.wr_data !== exp_a(ia.wr_addr)) bad_a++;
        else if (!seen_a[ia.wr_addr[8:0]]) begin seen_a[ia.wr_addr[8:0]] = 1'b1; dist_a++; end
        if (ia.wr_addr == 32'd33) d33_a = ia.wr_data;
      end
    end
  end

  initial begin
    int ep;
    logic [31:0] o;
    ep = -1;
    forever begin
      @(negedge clk);
      if (ep != epoch) begin
        ep = epoch; wcnt_b = 0; dist_b = 0; bad_b = 0; done_b = 0;
        first_addr_b = '0; first_data_b = '0;
        foreach (seen_b[i]) seen_b[i] = 1'b0;
      end
      if (ib.frame_done) done_b++;
      if (ib.wr_en) begin
        if (wcnt_b == 0) begin first_addr_b = ib.wr_addr; first_data_b = ib.wr_data; end
        wcnt_b++;
        o = ib.wr_addr - 32'd16;
        if (ib.wr_addr < 32'd16 || ib.wr_addr > 32'd23 || !ib.busy || ib.wr_data !== exp_b(ib.wr_addr)) bad_b++;
        else if (!seen_b[o[2:0]]) begin seen_b[o[2:0]] = 1'b1; dist_b++; end
      end
    end
  end

  int checks = 0, errors = 0;
  logic tmo = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_line(input int v);
    int n = 0;
    while (cur_v != v && n < LIMIT && !tmo) begin @(negedge clk); n++; end
    if (n >= LIMIT) tmo = 1'b1;
    check("wait_line_timeout", 32'(tmo), 32'd0);
  endtask

  task automatic wait_done_b();
    int n = 0;
    @(negedge clk);
    while (done_b == 0 && n < LIMIT && !tmo) begin @(negedge clk); n++; end
    if (n >= LIMIT) tmo = 1'b1;
    check("wait_done_timeout", 32'(tmo), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_clean(input string tag);
    check({tag, "_wcnt_a"}, wcnt_a, 512);
    check({tag, "_dist_a"}, dist_a, 512);
    check({tag, "_bad_a"},  bad_a, 0);
    check({tag, "_d33_a"},  d33_a, 32'h000101AA);
    check({tag, "_done_a"}, done_a, 1);
    check({tag, "_busy_a"}, ia.busy, 0);
    check({tag, "_wcnt_b"}, wcnt_b, 8);
    check({tag, "_dist_b"}, dist_b, 8);
    check({tag, "_bad_b"},  bad_b, 0);
    check({tag, "_first_addr_b"}, first_addr_b, 32'd16);
    check({tag, "_first_data_b"}, first_data_b, 32'h006432AA);
    check({tag, "_done_b"}, done_b, 1);
    check({tag, "_busy_b"}, ib.busy, 0);
  endtask

  initial begin
    start = 1'b0;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_busy_a", ia.busy, 0);
    check("rst_wr_en_a", ia.wr_en, 0);
    check("rst_wr_addr_a", ia.wr_addr, 0);
    check("rst_wr_data_a", ia.wr_data, 0);
    check("rst_frame_done_a", ia.frame_done, 0);
    check("rst_frame_err_a", ia.frame_err, 0);
    check("rst_busy_b", ib.busy, 0);
    reset = 1'b0;

    // Start mid-frame: nothing may be written until the next vsync.
    wait_line(20);
    epoch++;
    pulse_start();
    check("t1_busy_a", ia.busy, 1);
    check("t1_busy_b", ib.busy, 1);
    wait_line(V_ACT + V_FP);
    check("t1_prevs_wcnt_a", wcnt_a, 0);
    check("t1_prevs_wcnt_b", wcnt_b, 0);
    wait_done_b();
    check_clean("t1");
    check("t1_err_a", ia.frame_err, 0);
    check("t1_err_b", ib.frame_err, 0);
    wait_line(V_TOT - 1);
    check("t1_idle_wcnt_a", wcnt_a, 512);
    check("t1_idle_done_a", done_a, 1);

    // Starts while busy (waiting and capturing) are ignored.
    wait_line(30);
    epoch++;
    pulse_start();
    wait_line(40);
    pulse_start();
    check("t2_busy_wait", ib.busy, 1);
    wait_line(5);
    pulse_start();
    wait_done_b();
    check_clean("t2");
    wait_line(V_TOT - 1);
    check("t2_late_done_b", done_b, 1);
    check("t2_late_wcnt_b", wcnt_b, 8);

    // Frame cut after line 10, then a full frame completes the window.
    epoch++;
    pulse_start();
    wait_line(V_ACT + V_FP);
    wait_line(10);
    cut_line = 10;
    wait_line(V_ACT + V_FP);
    cut_line = -1;
    repeat (3) @(negedge clk);
    check("t3_err_a", ia.frame_err, 1);
    check("t3_err_b", ib.frame_err, 1);
    check("t3_busy_a", ia.busy, 1);
    check("t3_partial_wcnt_a", wcnt_a, 352);
    wait_done_b();
    check("t3_wcnt_a", wcnt_a, 864);
    check("t3_dist_a", dist_a, 512);
    check("t3_bad_a", bad_a, 0);
    check("t3_done_a", done_a, 1);
    check("t3_done_b", done_b, 1);
    check("t3_wcnt_b", wcnt_b, 8);
    check("t3_err_sticky_a", ia.frame_err, 1);

    // Reset during line 30 aborts; a later start captures cleanly.
    epoch++;
    pulse_start();
    check("t4_err_clr_a", ia.frame_err, 0);
    check("t4_err_clr_b", ib.frame_err, 0);
    wait_line(30);
    check("t4_pre_wcnt_a", wcnt_a, 512);
    check("t4_pre_busy_b", ib.busy, 1);
    reset = 1'b1;
    #1;
    check("t4_rst_wr_en_b", ib.wr_en, 0);
    check("t4_rst_busy_b", ib.busy, 0);
    check("t4_rst_busy_a", ia.busy, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    epoch++;
    pulse_start();
    wait_line(V_TOT - 1);
    check("t4_abort_wcnt_b", wcnt_b, 0);
    check("t4_abort_done_b", done_b, 0);
    wait_done_b();
    check_clean("t4");
    check("t4_err_a", ia.frame_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 Parameter X0, default 0: first captured active-pixel column.
REQ-002 Parameter Y0, default 0: first captured active line.
REQ-003 Parameter W, default 256: capture window width in pixels.
REQ-004 Parameter H, default 256: capture window height in lines.
REQ-005 Parameter BASE, default 0: word address of captured pixel (0,0).
REQ-006 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-007 Port reset, input, 1: asynchronous, active-high reset.
REQ-008 Port pix_en, input, 1: one-cycle pixel strobe (25 MHz rate); VGA inputs are valid on cycles where pix_en=1.
REQ-009 Port VGA_HS, input, 1: horizontal sync, active low.
REQ-010 Port VGA_VS, input, 1: vertical sync, active low.
REQ-011 Port VGA_BLANK_N, input, 1: 1 = active video pixel.
REQ-012 Port VGA_R / VGA_G / VGA_B, input, 8 each: pixel colour.
REQ-013 Port start, input, 1: single-cycle request to capture one frame.
REQ-014 Port busy, output, 1: capture in progress.
REQ-015 Port wr_en, output, 1: memory write strobe.
REQ-016 Port wr_addr, output, 32: word address of the write.
REQ-017 Port wr_data, output, 32: {8'h00, R, G, B}.
REQ-018 Port frame_done, output, 1: one-cycle pulse when the window is fully written.
REQ-019 Port frame_err, output, 1: sticky flag; frame ended before the window completed.

Function
REQ-020 The block SHALL sample VGA_HS, VGA_VS and VGA_BLANK_N only on pix_en cycles, and SHALL detect edges against the previously sampled values.
REQ-021 The state machine SHALL have states IDLE, WAIT_VS, CAPTURE and DONE.
REQ-022 IDLE: on start=1 the block SHALL move to WAIT_VS and set busy=1 in the next cycle; frame_err SHALL clear on that start.
REQ-023 WAIT_VS: on a sampled VGA_VS falling edge the block SHALL move to CAPTURE and clear x_cnt and y_cnt.
REQ-024 Counting: x_cnt SHALL increment on each pix_en with VGA_BLANK_N=1, and SHALL clear on a VGA_HS falling edge.
REQ-025 Counting: y_cnt SHALL increment on each VGA_BLANK_N falling edge, i.e. at the end of each active line.
REQ-026 Write condition: when X0 <= x_cnt < X0+W and Y0 <= y_cnt < H+Y0 on an active pixel, the block SHALL assert wr_en exactly one clk later for one cycle.
REQ-027 Write address: wr_addr = BASE + (y_cnt-Y0)*W + (x_cnt-X0), computed at 32-bit width with no wrap.
REQ-028 Write data: wr_data SHALL hold the pixel value registered with that pixel.
REQ-029 Completion: after the write of (W-1, H-1) the block SHALL move to DONE; the next cycle it SHALL pulse frame_done=1, set busy=0 and return to IDLE.
REQ-030 Early frame end: a VGA_VS falling edge in CAPTURE before completion SHALL set frame_err=1, clear both counters and restart capture with the new frame.
REQ-031 start while busy=1 SHALL be ignored.
REQ-032 Pixels beyond the VGA active area SHALL never be written; counters SHALL saturate rather than wrap.
REQ-033 wr_en SHALL be 0 in every state except CAPTURE.
REQ-034 At most one write SHALL occur per pix_en.

Reset
REQ-035 While reset=1 all outputs SHALL be 0: busy, wr_en, wr_addr, wr_data, frame_done and frame_err.
REQ-036 While reset=1 the state SHALL be IDLE and all counters and edge registers SHALL be 0.
REQ-037 Reset asserted mid-capture SHALL abort immediately with no further writes; after release the block SHALL wait for a new start.

Verification
REQ-038 Drive a 640x480 VGA pattern with pixel = {x[7:0], y[7:0], 8'hAA}, defaults, and pulse start -> exactly 65536 writes; the write at wr_addr=257 has wr_data=32'h000101AA; frame_done pulses once; busy falls.
REQ-039 Pulse start mid-frame -> no write occurs until the next VS falling edge.
REQ-040 Set X0=100, Y0=50, W=4, H=2, BASE=16 -> exactly 8 writes at addresses 16..23; the first write carries pixel (100,50).
REQ-041 Cut a frame short with VS after line 10, then play a full frame -> frame_err=1; the capture still completes with 65536 total valid writes from the second frame; frame_done pulses.
REQ-042 Assert reset during line 30 of a capture -> wr_en=0 and busy=0 within the same cycle; a later start captures a clean full frame.
REQ-043 Pulse start while busy=1 -> no state change and no extra frame_done.
